// File: rtl/fc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : fc_pkg                                                          |
// | Purpose  : Shared types and helpers for the fully-connected layer engine:  |
// |            FSM state encoding, a minimum-1 clog2 for address widths and    |
// |            the requantise/saturate function applied to each accumulator.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BIAS  = 3'd1,
      ST_MAC   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_EMIT  = 3'd4,
      ST_FIN   = 3'd5
   } state_t;

   // Width needed to address n items; never returns 0 so ports stay legal.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   // Arithmetic right shift then clamp: [0, 2^w-1] with relu, else the
   // signed range of a w-bit word. Caller keeps the low w bits.
   function automatic logic signed [63:0] sat_out(input logic signed [63:0] acc,
                                                  input int                 shift,
                                                  input logic               relu,
                                                  input int                 data_w);
      logic signed [63:0] r;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      r = acc >>> shift;
      if (relu) begin
         hi = (64'sd1 <<< data_w) - 64'sd1;
         lo = 64'sd0;
      end else begin
         hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
         lo = -(64'sd1 <<< (data_w - 1));
      end
      if (r > hi)      r = hi;
      else if (r < lo) r = lo;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fc_mac_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fc_mac_lane                                                     |
// | Purpose  : One signed MAC lane. A bias return overwrites the accumulator   |
// |            (sign-extended); a product return adds unsigned activation x    |
// |            signed weight at full precision, wrapping at ACC_W.             |
// | Ports    : clk, reset (sync, active-high, clears acc), bias_ld, mac_en,    |
// |            bias / w_data (signed), in_data (unsigned), acc (signed out).   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fc_mac_lane #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bias_ld,
   input  logic              mac_en,
   input  logic [DATA_W-1:0] bias,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] w_data,
   output logic [ACC_W-1:0]  acc
);

   logic [ACC_W-1:0]        acc_q;
   logic [ACC_W-1:0]        acc_d;
   logic signed [2*DATA_W:0] prod;

   always_comb begin
      // Zero-extended activation keeps the product sign correct for in >= 128.
      prod  = $signed({1'b0, in_data}) * $signed(w_data);
      acc_d = acc_q;
      if (bias_ld)
         acc_d = ACC_W'($signed(bias));
      else if (mac_en)
         acc_d = acc_q + ACC_W'(prod);
   end

   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule
`default_nettype wire

// File: rtl/fc_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fc_layer_engine                                                 |
// | Purpose  : Self-sequencing fully-connected layer. Per group of NUM_PARA    |
// |            neurons: read bias, stream NUM_IN input/weight pairs, wait for  |
// |            the last product, then emit requantised results on a            |
// |            valid/ready stream.                                             |
// | Ports    : clk, reset (sync, active-high); start/busy/done handshake;      |
// |            in_*, w_*, b_* memory read ports (fixed RD_LAT latency);        |
// |            out_valid/out_ready/out_idx/out_data result stream.             |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fc_layer_engine
   import fc_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 24,
   parameter int NUM_IN    = 84,
   parameter int NUM_OUT   = 10,
   parameter int NUM_PARA  = 2,
   parameter int RD_LAT    = 1,
   parameter int BIAS_BASE = 204,
   parameter int OUT_SHIFT = 0,
   parameter int RELU_EN   = 1,
   parameter int IN_AW     = clog2(NUM_IN),
   parameter int W_AW      = clog2(((NUM_OUT + NUM_PARA - 1) / NUM_PARA) * NUM_IN),
   parameter int B_AW      = clog2(BIAS_BASE + (NUM_OUT + NUM_PARA - 1) / NUM_PARA)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic                         in_re,
   output logic [IN_AW-1:0]             in_addr,
   input  logic [DATA_W-1:0]            in_rdata,
   output logic                         w_re,
   output logic [W_AW-1:0]              w_addr,
   input  logic [NUM_PARA*DATA_W-1:0]   w_rdata,
   output logic                         b_re,
   output logic [B_AW-1:0]              b_addr,
   input  logic [NUM_PARA*DATA_W-1:0]   b_rdata,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [clog2(NUM_OUT)-1:0]    out_idx,
   output logic [DATA_W-1:0]            out_data
);

   localparam int G   = (NUM_OUT + NUM_PARA - 1) / NUM_PARA;
   localparam int G_W = clog2(G);
   localparam int K_W = clog2(NUM_PARA);
   localparam int O_W = clog2(NUM_OUT);
   localparam int C_W = clog2(RD_LAT + 1);

   state_t              state_q, state_d;
   logic [G_W-1:0]      g_q, g_d;
   logic [K_W-1:0]      k_q, k_d;
   logic [C_W-1:0]      cnt_q, cnt_d;
   logic                busy_q, busy_d, done_q, done_d;
   logic                in_re_q, in_re_d, w_re_q, w_re_d, b_re_q, b_re_d;
   logic [IN_AW-1:0]    in_addr_q, in_addr_d;
   logic [W_AW-1:0]     w_addr_q, w_addr_d;
   logic [B_AW-1:0]     b_addr_q, b_addr_d;
   logic                out_valid_q, out_valid_d;
   logic [O_W-1:0]      out_idx_q, out_idx_d;
   // Delay lines marking which read is returning this cycle.
   logic [RD_LAT-1:0]   bias_pipe_q, bias_pipe_d, mac_pipe_q, mac_pipe_d;
   logic                last_lane;
   logic [ACC_W-1:0]    lane_acc [NUM_PARA];

   always_comb begin
      state_d     = state_q;
      g_d         = g_q;
      k_d         = k_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      in_re_d     = 1'b0;
      w_re_d      = 1'b0;
      b_re_d      = 1'b0;
      in_addr_d   = in_addr_q;
      w_addr_d    = w_addr_q;
      b_addr_d    = b_addr_q;
      out_valid_d = 1'b0;
      out_idx_d   = out_idx_q;

      for (int j = RD_LAT - 1; j > 0; j--) begin
         bias_pipe_d[j] = bias_pipe_q[j-1];
         mac_pipe_d[j]  = mac_pipe_q[j-1];
      end
      bias_pipe_d[0] = b_re_q;
      mac_pipe_d[0]  = in_re_q;

      // Phantom lanes past NUM_OUT end the group early.
      last_lane = (k_q == K_W'(NUM_PARA - 1)) || (out_idx_q == O_W'(NUM_OUT - 1));

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_BIAS;
               g_d      = '0;
               busy_d   = 1'b1;
               b_re_d   = 1'b1;
               b_addr_d = B_AW'(BIAS_BASE);
            end
         end
         ST_BIAS: begin
            state_d   = ST_MAC;
            in_re_d   = 1'b1;
            w_re_d    = 1'b1;
            in_addr_d = '0;
            w_addr_d  = W_AW'(g_q) * W_AW'(NUM_IN);
         end
         ST_MAC: begin
            if (in_addr_q == IN_AW'(NUM_IN - 1)) begin
               state_d = ST_DRAIN;
               cnt_d   = '0;
            end else begin
               in_re_d   = 1'b1;
               w_re_d    = 1'b1;
               in_addr_d = in_addr_q + IN_AW'(1);
               w_addr_d  = w_addr_q + W_AW'(1);
            end
         end
         ST_DRAIN: begin
            if (cnt_q == C_W'(RD_LAT - 1)) begin
               state_d     = ST_EMIT;
               k_d         = '0;
               out_valid_d = 1'b1;
               out_idx_d   = O_W'(g_q) * O_W'(NUM_PARA);
            end else begin
               cnt_d = cnt_q + C_W'(1);
            end
         end
         ST_EMIT: begin
            out_valid_d = 1'b1;
            if (out_ready) begin
               if (last_lane) begin
                  out_valid_d = 1'b0;
                  if (g_q == G_W'(G - 1)) begin
                     state_d = ST_FIN;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                  end else begin
                     state_d  = ST_BIAS;
                     g_d      = g_q + G_W'(1);
                     b_re_d   = 1'b1;
                     b_addr_d = B_AW'(BIAS_BASE) + B_AW'(g_q + G_W'(1));
                  end
               end else begin
                  k_d       = k_q + K_W'(1);
                  out_idx_d = out_idx_q + O_W'(1);
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         g_q         <= '0;
         k_q         <= '0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_re_q     <= 1'b0;
         w_re_q      <= 1'b0;
         b_re_q      <= 1'b0;
         in_addr_q   <= '0;
         w_addr_q    <= '0;
         b_addr_q    <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         bias_pipe_q <= '0;
         mac_pipe_q  <= '0;
      end else begin
         state_q     <= state_d;
         g_q         <= g_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         in_re_q     <= in_re_d;
         w_re_q      <= w_re_d;
         b_re_q      <= b_re_d;
         in_addr_q   <= in_addr_d;
         w_addr_q    <= w_addr_d;
         b_addr_q    <= b_addr_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         bias_pipe_q <= bias_pipe_d;
         mac_pipe_q  <= mac_pipe_d;
      end
   end

   for (genvar k = 0; k < NUM_PARA; k++) begin : g_lane
      fc_mac_lane #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .bias_ld (bias_pipe_q[RD_LAT-1]),
         .mac_en  (mac_pipe_q[RD_LAT-1]),
         .bias    (b_rdata[k*DATA_W +: DATA_W]),
         .in_data (in_rdata),
         .w_data  (w_rdata[k*DATA_W +: DATA_W]),
         .acc     (lane_acc[k])
      );
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign in_re     = in_re_q;
   assign in_addr   = in_addr_q;
   assign w_re      = w_re_q;
   assign w_addr    = w_addr_q;
   assign b_re      = b_re_q;
   assign b_addr    = b_addr_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   // Accumulators are frozen throughout EMIT, so this stays stable under backpressure.
   assign out_data  = out_valid_q
                    ? DATA_W'(sat_out(64'($signed(lane_acc[k_q])), OUT_SHIFT, RELU_EN != 0, DATA_W))
                    : '0;

endmodule
`default_nettype wire
